mole_spawner: RTL and testbench
===============================

// Module: mole_spawner
// PURPOSE
//   Upstream of the column decoder in the whack-a-mole game. Picks a pseudo-random column (0..2)
//   from a free-running LFSR and holds it for a programmable number of game ticks.
//   Ends the mole early on a hit, then waits a gap before spawning the next mole.
//   col_idx drives the decoder input directly. 2'd3 means "no mole", which the decoder maps to 3'b000.
// PARAMETERS
//   LFSR_WIDTH  16        LFSR register width (Galois, maximal-length taps from wam_pkg)
//   SEED        16'hACE1  LFSR reset value; must be nonzero
//   GAP_TICKS   4         ticks spent in GAP between moles (>=1)
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   reset      in   1  synchronous, active-high reset
//   enable     in   1  game running; low forces IDLE
//   tick       in   1  1-cycle game-time strobe from the rate divider
//   up_ticks   in   8  mole lifetime in ticks; sampled at spawn; 0 treated as 1
//   hit        in   1  player hit the active mole's column (level, already qualified upstream)
//   col_idx    out  2  active column 0..2, or 2'd3 when no mole
//   mole_active out 1  high while in UP
//   spawn      out  1  1-cycle pulse on the cycle col_idx becomes valid
//   hit_ack    out  1  1-cycle pulse: mole ended by hit
//   miss       out  1  1-cycle pulse: mole expired unhit
// BEHAVIOUR
//   Reset: state=IDLE, col_idx=2'd3, mole_active/spawn/hit_ack/miss=0, lfsr=SEED, counter=0.
//   LFSR advances every clk cycle except during reset, independent of state and enable.
//   FSM states are IDLE, GAP, PICK and UP. Outputs are registered; no combinational path from input to output.
//   IDLE: if enable, go to GAP and load counter=GAP_TICKS.
//   GAP: on tick, decrement; on a tick seen with counter==1, go to PICK. GAP lasts exactly GAP_TICKS ticks.
//   PICK: cand=lfsr[1:0]. If cand==3, stay (retry next cycle with the new LFSR value).
//     Otherwise latch col_idx=cand, pulse spawn, set mole_active, load counter=max(up_ticks,1), go to UP.
//   UP: if hit, pulse hit_ack, go to GAP, load GAP_TICKS, col_idx=3, clear mole_active.
//     Else on a tick with counter==1, pulse miss, with the same state/output updates. Else on tick, decrement.
//   Simultaneous hit and expiring tick: hit wins; hit_ack only, no miss.
//   hit outside UP is ignored.
//   enable low (any state) takes priority over all else: next state IDLE, col_idx=3, no pulses that cycle.
//   Latency: spawn/col_idx valid 1 cycle after the PICK entry cycle with accepted cand. hit_ack 1 cycle after hit.
//   Reset asserted mid-mole: immediate return to reset values next edge; no miss/hit_ack emitted.
//   tick and hit are single-cycle events; tick is never counted twice.
// CONFIGURATION
//   MOLE_NO_REPEAT_EN defined: PICK also rejects cand equal to the previous mole's column and retries.
//     Previous column is held in prev_col, reset value 2'd3, updated at each spawn.
//   Not defined: any cand 0..2 is accepted; prev_col logic absent.
// STRUCTURE
//   wam_pkg holds:
//     - state enum (ST_IDLE, ST_GAP, ST_PICK, ST_UP)
//     - COL_NONE=2'd3
//     - LFSR tap mask constant for width 16
//   Sub-module wam_lfsr (clk, reset, seed param, q) holds the LFSR. FSM and counters stay in mole_spawner.
// TESTING
//   1. Reset with enable=0 for 5 cycles: col_idx=3, all pulses 0, lfsr==16'hACE1 on the first cycle after reset.
//   2. enable=1, GAP_TICKS=4, tick every 10 cycles: spawn occurs after the 4th tick.
//      col_idx in {0,1,2}, mole_active=1.
//   3. up_ticks=3, no hit: miss pulses once, on the cycle after the 3rd tick after spawn. col_idx=3, then GAP again.
//   4. hit on the same cycle as the expiring tick: hit_ack=1, miss=0, next state GAP.
//   5. Force lfsr[1:0]=3 for 3 cycles: stay in PICK, no spawn.
//      With MOLE_NO_REPEAT_EN, 200 spawns never repeat a column back-to-back.
//   6. Drop enable mid-UP (and separately assert reset mid-UP): next cycle col_idx=3, mole_active=0, no miss/hit_ack.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole spawner path.
package wam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_PICK,
    ST_UP
  } state_e;

  localparam logic [1:0] COL_NONE = 2'd3;

  // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

endpackage

// File: rtl/wam_lfsr.sv
// Free-running Galois LFSR; reloads SEED on synchronous reset, otherwise steps every cycle.
module wam_lfsr #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else if (q[0]) begin
      q <= (q >> 1) ^ TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Picks a random column, holds it for up_ticks game ticks or until hit, then waits a gap.
// Optional macro MOLE_NO_REPEAT_EN: never spawn the same column twice in a row.
module mole_spawner
  import wam_pkg::*;
#(
  parameter int unsigned           LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1,
  parameter int unsigned           GAP_TICKS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic [7:0] up_ticks,
  input  logic       hit,
  output logic [1:0] col_idx,
  output logic       mole_active,
  output logic       spawn,
  output logic       hit_ack,
  output logic       miss
);

  localparam logic [7:0] gap_cnt = 8'(GAP_TICKS);

  logic [LFSR_WIDTH-1:0] lfsr;
  logic                  unused_lfsr;
  logic [1:0]            cand;
  logic                  accept;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] col_q, col_d;
  logic       active_q, active_d;
  logic       spawn_q, spawn_d;
  logic       hit_ack_q, hit_ack_d;
  logic       miss_q, miss_d;
  logic       expire;

  wam_lfsr #(
    .WIDTH(LFSR_WIDTH),
    .SEED (SEED),
    .TAPS (LFSR_WIDTH'(LFSR_TAPS_16))
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr)
  );

  assign cand        = lfsr[1:0];
  assign unused_lfsr = ^lfsr[LFSR_WIDTH-1:2];
  assign expire      = tick && (cnt_q == 8'd1);

`ifdef MOLE_NO_REPEAT_EN
  logic [1:0] prev_col_q;

  assign accept = (cand != COL_NONE) && (cand != prev_col_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_col_q <= COL_NONE;
    end else if (spawn_d) begin
      prev_col_q <= cand;
    end
  end
`else
  assign accept = (cand != COL_NONE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      col_q     <= COL_NONE;
      active_q  <= 1'b0;
      spawn_q   <= 1'b0;
      hit_ack_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      active_q  <= active_d;
      spawn_q   <= spawn_d;
      hit_ack_q <= hit_ack_d;
      miss_q    <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_GAP;
          cnt_d   = gap_cnt;
        end
        ST_GAP: begin
          if (tick) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = ST_PICK;
          end
        end
        ST_PICK: begin
          if (accept) begin
            state_d = ST_UP;
            cnt_d   = (up_ticks == 8'd0) ? 8'd1 : up_ticks;
          end
        end
        ST_UP: begin
          // Hit takes precedence over an expiring tick in the same cycle.
          if (hit || expire) begin
            state_d = ST_GAP;
            cnt_d   = gap_cnt;
          end else if (tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    col_d     = col_q;
    active_d  = active_q;
    spawn_d   = 1'b0;
    hit_ack_d = 1'b0;
    miss_d    = 1'b0;
    if (!enable) begin
      col_d    = COL_NONE;
      active_d = 1'b0;
    end else begin
      case (state_q)
        ST_PICK: begin
          if (accept) begin
            col_d    = cand;
            active_d = 1'b1;
            spawn_d  = 1'b1;
          end
        end
        ST_UP: begin
          if (hit || expire) begin
            hit_ack_d = hit;
            miss_d    = !hit;
            col_d     = COL_NONE;
            active_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign col_idx     = col_q;
  assign mole_active = active_q;
  assign spawn       = spawn_q;
  assign hit_ack     = hit_ack_q;
  assign miss        = miss_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: vector table, directed corner cases, random lockstep model.
module tb_mole_spawner;
  import wam_pkg::*;

  localparam int unsigned GAP  = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset, enable, tick, hit;
  logic [7:0] up_ticks;
  logic [1:0] col_idx;
  logic       mole_active, spawn, hit_ack, miss;

  int total = 0;
  int bad   = 0;

  mole_spawner #(
    .LFSR_WIDTH(16),
    .SEED      (SEED),
    .GAP_TICKS (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tick       (tick),
    .up_ticks   (up_ticks),
    .hit        (hit),
    .col_idx    (col_idx),
    .mole_active(mole_active),
    .spawn      (spawn),
    .hit_ack    (hit_ack),
    .miss       (miss)
  );

  always #5 clk = ~clk;

  // Reference model: game-level bookkeeping rather than an encoded state machine.
  logic [15:0] m_lfsr = SEED;
  bit          m_running = 0;
  bit          m_picking = 0;
  int          m_gap_left = 0;
  int          m_life_left = 0;
  int          m_mole = -1;
  int          m_prev = -1;
  bit          e_spawn, e_hit, e_miss;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ LFSR_TAPS_16;
    return r;
  endfunction

  task automatic model_step(input bit r, input bit en, input bit tk, input logic [7:0] ut,
                            input bit ht);
    int  c;
    bit  ok;
    e_spawn = 0;
    e_hit   = 0;
    e_miss  = 0;
    if (r) begin
      m_lfsr    = SEED;
      m_running = 0;
      m_picking = 0;
      m_mole    = -1;
      m_prev    = -1;
      return;
    end
    c      = int'(m_lfsr % 16'd4);
    m_lfsr = lfsr_step(m_lfsr);
    if (!en) begin
      m_running = 0;
      m_picking = 0;
      m_mole    = -1;
    end else if (!m_running) begin
      m_running  = 1;
      m_gap_left = GAP;
    end else if (m_mole >= 0) begin
      if (ht || (tk && m_life_left == 1)) begin
        e_hit      = ht;
        e_miss     = !ht;
        m_mole     = -1;
        m_gap_left = GAP;
      end else if (tk) begin
        m_life_left--;
      end
    end else if (m_picking) begin
      ok = (c != 3);
`ifdef MOLE_NO_REPEAT_EN
      if (c == m_prev) ok = 0;
`endif
      if (ok) begin
        m_mole      = c;
        m_prev      = c;
        m_life_left = (ut == 0) ? 1 : int'(ut);
        m_picking   = 0;
        e_spawn     = 1;
      end
    end else if (tk) begin
      m_gap_left--;
      if (m_gap_left == 0) m_picking = 1;
    end
  endtask

  function automatic logic [5:0] model_outs();
    logic [1:0] col;
    col = (m_mole < 0) ? 2'd3 : 2'(m_mole);
    return {col, m_mole >= 0, e_spawn, e_hit, e_miss};
  endfunction

  task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b ({col,active,spawn,hit_ack,miss}) t=%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {col_idx, mole_active, spawn, hit_ack, miss};
  endfunction

  // One clock: drive, step the DUT and the model, compare every output.
  task automatic cycle(input bit r, input bit en, input bit tk, input logic [7:0] ut,
                       input bit ht, input string name);
    reset    = r;
    enable   = en;
    tick     = tk;
    up_ticks = ut;
    hit      = ht;
    @(posedge clk);
    #1;
    model_step(r, en, tk, ut, ht);
    check6(name, outs(), model_outs());
  endtask

  task automatic wait_spawn(input int period, input logic [7:0] ut, input string name);
    int n;
    n = 0;
    while (spawn !== 1'b1 && n < 300) begin
      cycle(0, 1, (n % period) == period - 1, ut, 0, name);
      n++;
    end
    total++;
    if (spawn !== 1'b1) begin
      bad++;
      $display("FAIL %s: got no spawn want spawn within 300 cycles", name);
    end
  endtask

  typedef struct {
    bit         r;
    bit         en;
    bit         tk;
    bit         ht;
    logic [5:0] exp;
  } vec_t;

  localparam logic [5:0] IDLE_OUT = 6'b11_0_000;

  vec_t tbl[14];
  int   last_col;
  int   spawns;
  bit   rr, ren, rtk, rht;
  logic [7:0] rut;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    tick     = 1'b0;
    hit      = 1'b0;
    up_ticks = 8'd3;

    // Reset with noise, enable-low idle, then a fully determined run-up through the gap.
    tbl[0]  = '{1, 0, 0, 0, IDLE_OUT};
    tbl[1]  = '{1, 0, 1, 0, IDLE_OUT};
    tbl[2]  = '{1, 0, 0, 1, IDLE_OUT};
    tbl[3]  = '{1, 1, 1, 1, IDLE_OUT};
    tbl[4]  = '{1, 0, 0, 0, IDLE_OUT};
    tbl[5]  = '{0, 0, 1, 0, IDLE_OUT};
    tbl[6]  = '{0, 0, 0, 1, IDLE_OUT};
    tbl[7]  = '{0, 0, 1, 1, IDLE_OUT};
    tbl[8]  = '{0, 1, 0, 0, IDLE_OUT};
    tbl[9]  = '{0, 1, 1, 1, IDLE_OUT};
    tbl[10] = '{0, 1, 1, 0, IDLE_OUT};
    tbl[11] = '{0, 1, 0, 1, IDLE_OUT};
    tbl[12] = '{0, 1, 1, 0, IDLE_OUT};
    tbl[13] = '{0, 1, 1, 0, IDLE_OUT};

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].r, tbl[i].en, tbl[i].tk, 8'd3, tbl[i].ht, "tbl_model");
      check6($sformatf("tbl_row%0d", i), outs(), tbl[i].exp);
      if (i == 4) check16("lfsr_after_reset", dut.lfsr, SEED);
    end

    // Gap elapsed after the 4th tick; mole must appear with a valid column.
    wait_spawn(10, 8'd3, "first_spawn");
    check1("spawn_col_valid", (col_idx != 2'd3) && mole_active, 1'b1);

    // Lifetime 3 ticks, no hit: miss exactly once, right after the 3rd tick.
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 9; j++) cycle(0, 1, 0, 8'd3, 0, "life_wait");
      cycle(0, 1, 1, 8'd3, 0, "life_tick");
      if (k < 3) check1("no_early_miss", miss, 1'b0);
    end
    check6("miss_on_3rd_tick", outs(), 6'b11_0_001);
    cycle(0, 1, 0, 8'd3, 0, "after_miss");
    check1("miss_single_pulse", miss, 1'b0);

    // Hit coincident with the expiring tick: hit wins.
    wait_spawn(10, 8'd3, "second_spawn");
    cycle(0, 1, 1, 8'd3, 0, "hm_tick1");
    cycle(0, 1, 1, 8'd3, 0, "hm_tick2");
    cycle(0, 1, 1, 8'd3, 1, "hm_tick3_hit");
    check6("hit_beats_expire", outs(), 6'b11_0_010);

    // Lifetime 0 behaves as 1 tick.
    wait_spawn(10, 8'd0, "zero_life_spawn");
    cycle(0, 1, 1, 8'd0, 0, "zero_life_tick");
    check6("zero_life_miss", outs(), 6'b11_0_001);

    // Enable dropped mid-mole with hit and expiring tick present.
    wait_spawn(10, 8'd1, "third_spawn");
    cycle(0, 0, 1, 8'd1, 1, "en_drop");
    check6("en_drop_clears", outs(), IDLE_OUT);

    // Reset mid-mole.
    wait_spawn(5, 8'd1, "fourth_spawn");
    cycle(1, 1, 1, 8'd1, 1, "reset_mid_up");
    check6("reset_clears", outs(), IDLE_OUT);
    check16("lfsr_reseeded", dut.lfsr, SEED);

    // Random lockstep run against the model.
    last_col = -1;
    spawns   = 0;
    for (int i = 0; i < 8000; i++) begin
      rr  = ($urandom_range(0, 1999) == 0);
      ren = ($urandom_range(0, 299) != 0);
      rtk = ($urandom_range(0, 1) == 0);
      rht = ($urandom_range(0, 7) == 0);
      rut = 8'($urandom_range(0, 3));
      cycle(rr, ren, rtk, rut, rht, "rand");
      if (rr) last_col = -1;
      if (spawn === 1'b1) begin
        spawns++;
`ifdef MOLE_NO_REPEAT_EN
        total++;
        if (int'(col_idx) == last_col) begin
          bad++;
          $display("FAIL no_repeat: got col %0d want differs from previous %0d", col_idx,
                   last_col);
        end
`endif
        last_col = int'(col_idx);
      end
    end
    check1("enough_spawns", spawns >= 200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
